// File: rtl/kernel_launch_m_axil.sv
// AXI4-Lite master that programs kernel arguments, sets ap_start and
// polls AP_CTRL until ap_done, then reports completion to the requester.
module kernel_launch_m_axil #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int POLL_GAP   = 4,
    parameter int MAX_POLLS  = 0
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [31:0]           cmd_scalar00,
    input  logic [63:0]           cmd_A,
    input  logic [63:0]           cmd_B,
    output logic                  done_valid,
    output logic [1:0]            done_status,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] M_AWADDR,
    output logic                  M_AWVALID,
    input  logic                  M_AWREADY,
    output logic [DATA_WIDTH-1:0] M_WDATA,
    output logic [3:0]            M_WSTRB,
    output logic                  M_WVALID,
    input  logic                  M_WREADY,
    input  logic [1:0]            M_BRESP,
    input  logic                  M_BVALID,
    output logic                  M_BREADY,
    output logic [ADDR_WIDTH-1:0] M_ARADDR,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RVALID,
    output logic                  M_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_POLL_RD,
        S_RD_RESP,
        S_POLL_WAIT,
        S_DONE
    } state_e;

    localparam int CW = 16;
    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_BUS = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;

    state_e          state_q, state_d;
    logic [2:0]      widx_q, widx_d;
    logic [31:0]     scalar_q, scalar_d;
    logic [63:0]     a_q, a_d;
    logic [63:0]     b_q, b_d;
    logic            aw_hs_q, aw_hs_d;
    logic            w_hs_q, w_hs_d;
    logic [CW-1:0]   poll_q, poll_d;
    logic [CW-1:0]   gap_q, gap_d;
    logic [1:0]      status_q, status_d;
    logic [CW-1:0]   poll_inc;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]     wr_data;
    logic            unused_rdata;

    assign poll_inc = poll_q + CW'(1);
    assign unused_rdata = ^{M_RDATA[DATA_WIDTH-1:2], M_RDATA[0]};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= S_IDLE;
            widx_q   <= '0;
            scalar_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aw_hs_q  <= 1'b0;
            w_hs_q   <= 1'b0;
            poll_q   <= '0;
            gap_q    <= '0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            widx_q   <= widx_d;
            scalar_q <= scalar_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aw_hs_q  <= aw_hs_d;
            w_hs_q   <= w_hs_d;
            poll_q   <= poll_d;
            gap_q    <= gap_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        widx_d   = widx_q;
        scalar_d = scalar_q;
        a_d      = a_q;
        b_d      = b_q;
        aw_hs_d  = aw_hs_q;
        w_hs_d   = w_hs_q;
        poll_d   = poll_q;
        gap_d    = gap_q;
        status_d = status_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    scalar_d = cmd_scalar00;
                    a_d      = cmd_A;
                    b_d      = cmd_B;
                    widx_d   = '0;
                    aw_hs_d  = 1'b0;
                    w_hs_d   = 1'b0;
                    state_d  = S_WR;
                end
            end
            S_WR: begin
                // AW and W complete independently, in either order
                aw_hs_d = aw_hs_q | M_AWREADY;
                w_hs_d  = w_hs_q | M_WREADY;
                if (aw_hs_d && w_hs_d) state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (M_BVALID) begin
                    if (M_BRESP != 2'b00) begin
                        status_d = ST_BUS;
                        state_d  = S_DONE;
                    end else if (widx_q == 3'd5) begin
                        poll_d  = '0;
                        state_d = S_POLL_RD;
                    end else begin
                        widx_d  = widx_q + 3'd1;
                        aw_hs_d = 1'b0;
                        w_hs_d  = 1'b0;
                        state_d = S_WR;
                    end
                end
            end
            S_POLL_RD: begin
                if (M_ARREADY) state_d = S_RD_RESP;
            end
            S_RD_RESP: begin
                if (M_RVALID) begin
                    if (M_RRESP != 2'b00) begin
                        status_d = ST_BUS;
                        state_d  = S_DONE;
                    end else if (M_RDATA[1]) begin
                        status_d = ST_OK;
                        state_d  = S_DONE;
                    end else begin
                        poll_d = poll_inc;
                        if ((MAX_POLLS != 0) &&
                            (poll_inc == CW'(MAX_POLLS))) begin
                            status_d = ST_TMO;
                            state_d  = S_DONE;
                        end else if (POLL_GAP == 0) begin
                            state_d = S_POLL_RD;
                        end else begin
                            gap_d   = '0;
                            state_d = S_POLL_WAIT;
                        end
                    end
                end
            end
            S_POLL_WAIT: begin
                if (gap_q == CW'(POLL_GAP - 1)) state_d = S_POLL_RD;
                else gap_d = gap_q + CW'(1);
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_addr = '0;
        wr_data = 32'h1;
        case (widx_q)
            3'd0: begin wr_addr = ADDR_WIDTH'('h10); wr_data = scalar_q; end
            3'd1: begin wr_addr = ADDR_WIDTH'('h18); wr_data = a_q[31:0]; end
            3'd2: begin wr_addr = ADDR_WIDTH'('h1C); wr_data = a_q[63:32]; end
            3'd3: begin wr_addr = ADDR_WIDTH'('h24); wr_data = b_q[31:0]; end
            3'd4: begin wr_addr = ADDR_WIDTH'('h28); wr_data = b_q[63:32]; end
            default: begin wr_addr = '0; wr_data = 32'h1; end
        endcase
    end

    assign M_AWADDR    = wr_addr;
    assign M_WDATA     = wr_data;
    assign M_WSTRB     = 4'hF;
    assign M_AWVALID   = (state_q == S_WR) && !aw_hs_q;
    assign M_WVALID    = (state_q == S_WR) && !w_hs_q;
    assign M_BREADY    = (state_q == S_WR_RESP);
    assign M_ARADDR    = '0;
    assign M_ARVALID   = (state_q == S_POLL_RD);
    assign M_RREADY    = (state_q == S_RD_RESP);
    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done_valid  = (state_q == S_DONE);
    assign done_status = status_q;

endmodule
